md_sched: RTL

Multiply/divide scheduler for the five-stage pipeline. It accepts mult/div/mthi/mtlo issues from the E stage, counts the fixed operation latency, and commits results to the HI/LO registers. It drives the stall that holds D-stage instructions that use HI/LO, and its hi/lo outputs feed the E/M result mux that propagates into the W-stage register.

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_sched_if.sv | 26 ++
 rtl/md_lat_cnt.sv | 27 ++
 rtl/md_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM states,
// default latencies and the mult/div classifier.
package md_pkg;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage issue / D-stage interlock / HI-LO result bundle between the pipeline
// (master) and the multiply/divide scheduler (slave).
interface md_sched_if;

   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        d_md_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, flush, d_md_use,
      input  busy, stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, d_md_use,
      output busy, stall, hi, lo
   );

endinterface

// File: rtl/md_lat_cnt.sv
// 5-bit load/decrement latency counter; last flags the commit cycle.
module md_lat_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [4:0] load_value,
   input  logic       en,
   output logic       last,
   output logic       zero
);

   logic [4:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= 5'd0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != 5'd0)) begin
         count <= count - 5'd1;
      end
   end

   assign last = (count == 5'd1);
   assign zero = (count == 5'd0);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed-latency mult/div into HI/LO plus D-stage stall.
// Optional MD_DIV0_FLAG_EN adds a one-cycle div0 pulse after a divide-by-zero commit.
//
//   state | meaning
//   IDLE  | no mult/div in flight; issues and mthi/mtlo are accepted
//   RUN   | mult/div in flight; counter runs down to the commit cycle
module md_sched
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   md_sched_if.slave  md
`ifdef MD_DIV0_FLAG_EN
   ,
   output logic       div0
`endif
);

   localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

   md_state_e   state, state_nxt;
   logic        accept, accept_md, commit;
   logic        cnt_last, cnt_zero;
   logic        is_mul, sign_op;
   logic [4:0]  lat_value;
   logic [63:0] prod;
   logic [31:0] abs_a, abs_b, q_mag, r_mag, quo, rem;
   logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
   logic        pend_skip;

   assign accept    = md.start && !md.flush && (state == IDLE);
   assign accept_md = accept && is_muldiv(md.op);
   assign commit    = (state == RUN) && cnt_last;

   assign is_mul    = (md.op == MD_MULT) || (md.op == MD_MULTU);
   assign sign_op   = (md.op == MD_MULT) || (md.op == MD_DIV);
   assign lat_value = is_mul ? MULT_LAT : DIV_LAT;

   // Signed divide is done on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
   always_comb begin
      prod  = sign_op ? ({{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b})
                      : ({32'b0, md.a} * {32'b0, md.b});
      abs_a = (sign_op && md.a[31]) ? -md.a : md.a;
      abs_b = (sign_op && md.b[31]) ? -md.b : md.b;
      q_mag = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
      r_mag = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
      quo   = (sign_op && (md.a[31] ^ md.b[31])) ? -q_mag : q_mag;
      rem   = (sign_op && md.a[31]) ? -r_mag : r_mag;
   end

   md_lat_cnt u_lat_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (accept_md),
      .load_value (lat_value),
      .en         (state == RUN),
      .last       (cnt_last),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A zero counter in RUN can only follow a zero latency load; fall back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_md) state_nxt = RUN;
         RUN:     if (cnt_last || cnt_zero) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_skip <= 1'b0;
      end else begin
         if (accept_md) begin
            pend_hi   <= is_mul ? prod[63:32] : rem;
            pend_lo   <= is_mul ? prod[31:0]  : quo;
            pend_skip <= !is_mul && (md.b == 32'd0);
         end
         if (commit && !pend_skip) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
         end
         if (accept && (md.op == MD_MTHI)) hi_q <= md.a;
         if (accept && (md.op == MD_MTLO)) lo_q <= md.a;
      end
   end

`ifdef MD_DIV0_FLAG_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         div0 <= 1'b0;
      end else begin
         div0 <= commit && pend_skip;
      end
   end
`endif

   assign md.busy  = (state == RUN);
   assign md.stall = md.d_md_use && ((state == RUN) || (md.start && !md.flush && is_muldiv(md.op)));
   assign md.hi    = hi_q;
   assign md.lo    = lo_q;

endmodule
